// File: rtl/mem_ctrl_if.sv
// Request/acknowledge signals from the IF and MEM stages plus the 8-bit RAM/IO port,
// bundled so mem_ctrl and its surroundings share one definition.
interface mem_ctrl_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        flush_i;
  logic        if_ack_o;
  logic [31:0] if_data_o;

  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_ack_o;
  logic [31:0] mem_rdata_o;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    input  mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
    input  mem_din,
    output if_ack_o, if_data_o, mem_ack_o, mem_rdata_o,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req_i, if_addr_i, flush_i,
    output mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
    output mem_din,
    input  if_ack_o, if_data_o, mem_ack_o, mem_rdata_o,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrated byte-serial memory engine: splits 1/2/4-byte IF/MEM accesses into little-endian
// byte transfers on the single RAM/IO port and returns a one-cycle acknowledge to the owner.
module mem_ctrl (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ACK  = 2'd3
  } state_e;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [31:0] last_a_q, last_a_d;
  logic [7:0]  last_dout_q, last_dout_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  iss_q, iss_d;
  logic [2:0]  cap_q, cap_d;
  logic        owner_q, owner_d;
  logic        pend_q, pend_d;
  logic        paused_q, paused_d;

  logic [2:0]  req_len;
  logic [2:0]  iss_eff;
  logic        pend_eff;
  logic [31:0] a_out;
  logic [7:0]  dout_out;
  logic        wr_out;
  logic        if_ack;
  logic        mem_ack;

  always_comb begin
    case (bus.mem_size_i)
      2'd0:    req_len = 3'd1;
      2'd1:    req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
  end

  // After a pause the byte whose read slot was lost is re-issued from the capture pointer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    len_d       = len_q;
    iss_d       = iss_q;
    cap_d       = cap_q;
    owner_d     = owner_q;
    pend_d      = pend_q;
    paused_d    = paused_q;
    a_out       = 32'd0;
    dout_out    = 8'd0;
    wr_out      = 1'b0;
    if_ack      = 1'b0;
    mem_ack     = 1'b0;
    iss_eff     = paused_q ? cap_q : iss_q;
    pend_eff    = pend_q & ~paused_q;

    case (state_q)
      IDLE: begin
        if (rdy_in) begin
          if (bus.mem_req_i) begin
            state_d  = bus.mem_we_i ? WR : RD;
            addr_d   = bus.mem_addr_i;
            wdata_d  = bus.mem_wdata_i;
            len_d    = req_len;
            owner_d  = OWNER_MEM;
            iss_d    = 3'd0;
            cap_d    = 3'd0;
            pend_d   = 1'b0;
            paused_d = 1'b0;
            data_d   = 32'd0;
          end else if (bus.if_req_i && !bus.flush_i) begin
            state_d  = RD;
            addr_d   = bus.if_addr_i;
            wdata_d  = 32'd0;
            len_d    = 3'd4;
            owner_d  = OWNER_IF;
            iss_d    = 3'd0;
            cap_d    = 3'd0;
            pend_d   = 1'b0;
            paused_d = 1'b0;
            data_d   = 32'd0;
          end
        end
      end
      RD: begin
        if (!rdy_in) begin
          a_out    = last_a_q;
          paused_d = 1'b1;
        end else begin
          paused_d = 1'b0;
          iss_d    = iss_eff;
          pend_d   = 1'b0;
          if (iss_eff < len_q) begin
            a_out  = addr_q + {29'd0, iss_eff};
            iss_d  = iss_eff + 3'd1;
            pend_d = 1'b1;
          end
          if (pend_eff) begin
            data_d[{cap_q[1:0], 3'b000} +: 8] = bus.mem_din;
            cap_d = cap_q + 3'd1;
            if (cap_q == len_q - 3'd1) begin
              state_d = ACK;
            end
          end
        end
      end
      WR: begin
        if (!rdy_in) begin
          a_out    = last_a_q;
          dout_out = last_dout_q;
        end else begin
          a_out    = addr_q + {29'd0, iss_q};
          dout_out = wdata_q[{iss_q[1:0], 3'b000} +: 8];
          wr_out   = 1'b1;
          iss_d    = iss_q + 3'd1;
          if (iss_q == len_q - 3'd1) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (rdy_in) begin
          state_d = IDLE;
          if (owner_q == OWNER_MEM) begin
            mem_ack     = 1'b1;
            mem_rdata_d = data_q;
          end else if (!bus.flush_i) begin
            if_ack    = 1'b1;
            if_data_d = data_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A taken branch kills only fetches; MEM-owned transfers always run to completion.
    if (bus.flush_i && (owner_q == OWNER_IF) && ((state_q == RD) || (state_q == ACK))) begin
      state_d = IDLE;
    end

    last_a_d    = a_out;
    last_dout_d = dout_out;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      data_q      <= 32'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      last_a_q    <= 32'd0;
      last_dout_q <= 8'd0;
      len_q       <= 3'd0;
      iss_q       <= 3'd0;
      cap_q       <= 3'd0;
      owner_q     <= OWNER_IF;
      pend_q      <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      last_a_q    <= last_a_d;
      last_dout_q <= last_dout_d;
      len_q       <= len_d;
      iss_q       <= iss_d;
      cap_q       <= cap_d;
      owner_q     <= owner_d;
      pend_q      <= pend_d;
      paused_q    <= paused_d;
    end
  end

  assign bus.mem_a       = a_out;
  assign bus.mem_dout    = dout_out;
  assign bus.mem_wr      = wr_out;
  assign bus.if_ack_o    = if_ack;
  assign bus.mem_ack_o   = mem_ack;
  assign bus.if_data_o   = if_ack ? data_q : if_data_q;
  assign bus.mem_rdata_o = mem_ack ? data_q : mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: a byte RAM behind the port, a shadow memory as reference model,
// a table of directed accesses, hand-written multi-cycle corner cases and random traffic.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   total = 0;
  int   bad   = 0;

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram    [logic [31:0]];
  logic [7:0] shadow [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E3779B1;
    return h[31:24] ^ h[7:0];
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_byte(a);
  endfunction

  // RAM device: synchronous write, one-cycle registered read.
  always @(posedge clk_in) begin
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
  end
  always @(posedge clk_in) begin
    bus.mem_din <= ram_rd(bus.mem_a);
  end

  // Reference model: access length, byte lists and ack latency from the timing rules.
  function automatic int n_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < n; k++) r = r | ({24'd0, sh_rd(a + 32'(k))} << (8 * k));
    return r;
  endfunction

  function automatic int model_ack(input bit we, input int n, input int s, input int l);
    if (we) return n + 1 + l;
    if (l == 0) return n + 2;
    return n + 2 + l + ((s >= 2) ? 1 : 0);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      ram[a + 32'(k)]    = w[8*k +: 8];
      shadow[a + 32'(k)] = w[8*k +: 8];
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: no acknowledge within cycle budget", name);
  endtask

  // Runs one access starting in the current cycle (cycle 0) and checks it against the model.
  task automatic applyStimulus(input string tag, input bit is_mem, input bit we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int st_s, input int st_l, input int exp_ack,
                               input bit chk_data, input logic [31:0] exp_data);
    int          n;
    int          ack_cyc;
    int          wrong_ack;
    int          a_hits;
    logic [31:0] got;
    logic [31:0] wa[$];
    logic [7:0]  wd[$];
    logic [31:0] ia[$];
    n = n_of(size);
    ack_cyc = -1;
    wrong_ack = 0;
    a_hits = 0;
    got = 32'd0;
    if (is_mem) begin
      bus.mem_req_i   = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_size_i  = size;
      bus.mem_addr_i  = addr;
      bus.mem_wdata_i = wdata;
    end else begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = addr;
    end
    for (int c = 0; c < 80 && ack_cyc < 0; c++) begin
      rdy_in = !(st_l > 0 && c >= st_s && c < st_s + st_l);
      @(negedge clk_in);
      if (bus.mem_wr) begin
        wa.push_back(bus.mem_a);
        wd.push_back(bus.mem_dout);
      end
      if (c >= 1 && c <= n) ia.push_back(bus.mem_a);
      if (bus.mem_a == addr) a_hits++;
      if ((is_mem && bus.if_ack_o) || (!is_mem && bus.mem_ack_o)) wrong_ack++;
      if (is_mem ? bus.mem_ack_o : bus.if_ack_o) begin
        ack_cyc = c;
        got = is_mem ? bus.mem_rdata_o : bus.if_data_o;
      end
      @(posedge clk_in);
      #1;
    end
    bus.mem_req_i = 1'b0;
    bus.if_req_i  = 1'b0;
    rdy_in        = 1'b1;
    @(negedge clk_in);
    checkOutput({tag, " ack_width"}, {30'd0, bus.if_ack_o, bus.mem_ack_o}, 32'd0);
    @(posedge clk_in);
    #1;
    if (ack_cyc < 0) begin
      failNow({tag, " ack_timeout"});
    end else begin
      checkOutput({tag, " ack_cycle"}, 32'(ack_cyc), 32'(exp_ack));
      if (chk_data) checkOutput({tag, " data"}, got, exp_data);
    end
    checkOutput({tag, " wrong_ack"}, 32'(wrong_ack), 32'd0);
    checkOutput({tag, " wr_count"}, 32'(wa.size()), we ? 32'(n) : 32'd0);
    if (we) begin
      for (int k = 0; k < n && k < wa.size(); k++) begin
        checkOutput({tag, " wr_addr"}, wa[k], addr + 32'(k));
        checkOutput({tag, " wr_byte"}, {24'd0, wd[k]}, {24'd0, wdata[8*k +: 8]});
        shadow[addr + 32'(k)] = wdata[8*k +: 8];
      end
      for (int k = 0; k < n; k++)
        checkOutput({tag, " ram"}, {24'd0, ram_rd(addr + 32'(k))}, {24'd0, sh_rd(addr + 32'(k))});
    end else if (st_l == 0) begin
      for (int k = 0; k < n && k < ia.size(); k++)
        checkOutput({tag, " rd_addr"}, ia[k], addr + 32'(k));
      if (addr != 32'd0) checkOutput({tag, " addr_hits"}, 32'(a_hits), 32'd1);
    end
  endtask

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          st_s;
    int          st_l;
    logic [31:0] ram_w;
    int          exp_ack;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          c_mem;
    int          c_if;
    int          cnt;
    logic [31:0] d;
    logic [7:0]  st_b[$];

    vecs[0]  = '{1'b0, 1'b0, 2'd2, 32'h00000100, 32'h0,        0, 0, 32'h00000513, 6,  32'h00000513};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 32'h00030000, 32'h0,        0, 0, 32'h00000041, 3,  32'h00000041};
    vecs[2]  = '{1'b1, 1'b0, 2'd1, 32'h00000201, 32'h0,        0, 0, 32'hCAFE1234, 4,  32'h00001234};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 32'h00000400, 32'h0,        2, 3, 32'h12345678, 10, 32'h12345678};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 32'hFFFFFFFF, 32'h0,        0, 0, 32'h0000BBAA, 4,  32'h0000BBAA};
    vecs[5]  = '{1'b1, 1'b1, 2'd2, 32'h00000200, 32'hDEADBEEF, 0, 0, 32'h0,        5,  32'h0};
    vecs[6]  = '{1'b1, 1'b1, 2'd0, 32'h00000300, 32'h000000A5, 0, 0, 32'h0,        2,  32'h0};
    vecs[7]  = '{1'b1, 1'b1, 2'd1, 32'h00000301, 32'h1234ABCD, 0, 0, 32'h0,        3,  32'h0};
    vecs[8]  = '{1'b1, 1'b1, 2'd2, 32'h00000340, 32'h0BADF00D, 2, 2, 32'h0,        7,  32'h0};
    vecs[9]  = '{1'b1, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0,        0, 0, 32'h44332211, 6,  32'h44332211};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 32'h00000104, 32'h0,        1, 2, 32'h00A00093, 8,  32'h00A00093};
    vecs[11] = '{1'b1, 1'b0, 2'd3, 32'h00000800, 32'h0,        0, 0, 32'h89ABCDEF, 6,  32'h89ABCDEF};

    rst_in          = 1'b0;
    rdy_in          = 1'b1;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 32'd0;
    bus.flush_i     = 1'b0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_size_i  = 2'd0;
    bus.mem_addr_i  = 32'd0;
    bus.mem_wdata_i = 32'd0;

    repeat (3) @(negedge clk_in);
    checkOutput("reset if_ack",    {31'd0, bus.if_ack_o},  32'd0);
    checkOutput("reset mem_ack",   {31'd0, bus.mem_ack_o}, 32'd0);
    checkOutput("reset mem_wr",    {31'd0, bus.mem_wr},    32'd0);
    checkOutput("reset mem_a",     bus.mem_a,              32'd0);
    checkOutput("reset mem_dout",  {24'd0, bus.mem_dout},  32'd0);
    checkOutput("reset if_data",   bus.if_data_o,          32'd0);
    checkOutput("reset mem_rdata", bus.mem_rdata_o,        32'd0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    for (int v = 0; v < 12; v++) begin
      preload(vecs[v].addr, vecs[v].ram_w);
      applyStimulus($sformatf("vec%0d", v), vecs[v].is_mem, vecs[v].we, vecs[v].size, vecs[v].addr,
                    vecs[v].wdata, vecs[v].st_s, vecs[v].st_l, vecs[v].exp_ack, !vecs[v].we,
                    vecs[v].exp_data);
    end

    // MEM store and IF fetch requested together: the store goes first.
    preload(32'h00000100, 32'h00000513);
    c_mem = -1;
    c_if  = -1;
    d     = 32'd0;
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = 1'b1;
    bus.mem_size_i  = 2'd2;
    bus.mem_addr_i  = 32'h00000200;
    bus.mem_wdata_i = 32'hDEADBEEF;
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 32'h00000100;
    for (int c = 0; c < 40 && (c_mem < 0 || c_if < 0); c++) begin
      @(negedge clk_in);
      if (bus.mem_wr && c >= 1 && c <= 4) st_b.push_back(bus.mem_dout);
      if (bus.mem_ack_o) c_mem = c;
      if (bus.if_ack_o) begin
        c_if = c;
        d = bus.if_data_o;
      end
      @(posedge clk_in);
      #1;
      if (c_mem >= 0) bus.mem_req_i = 1'b0;
      if (c_if >= 0)  bus.if_req_i  = 1'b0;
    end
    bus.mem_req_i = 1'b0;
    bus.if_req_i  = 1'b0;
    checkOutput("arb mem_ack_cycle", 32'(c_mem), 32'd5);
    checkOutput("arb if_ack_cycle",  32'(c_if),  32'd12);
    checkOutput("arb if_data",       d,          32'h00000513);
    checkOutput("arb store_bytes",   32'(st_b.size()), 32'd4);
    for (int k = 0; k < 4 && k < st_b.size(); k++)
      checkOutput("arb store_byte", {24'd0, st_b[k]}, {24'd0, 8'(32'hDEADBEEF >> (8 * k))});
    for (int k = 0; k < 4; k++) shadow[32'h200 + 32'(k)] = 8'(32'hDEADBEEF >> (8 * k));
    @(posedge clk_in);
    #1;

    // Fetch flushed in cycle 3, new fetch requested from cycle 4.
    preload(32'h00000500, 32'h11111111);
    preload(32'h00000600, 32'h00100073);
    c_if = -1;
    cnt  = 0;
    d    = 32'd0;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h00000500;
    for (int c = 0; c < 40 && c_if < 0; c++) begin
      bus.flush_i = (c == 3);
      if (c == 4) bus.if_addr_i = 32'h00000600;
      @(negedge clk_in);
      if (c == 5) checkOutput("flush new_addr", bus.mem_a, 32'h00000600);
      if (bus.if_ack_o) begin
        cnt++;
        c_if = c;
        d = bus.if_data_o;
      end
      @(posedge clk_in);
      #1;
    end
    bus.if_req_i = 1'b0;
    bus.flush_i  = 1'b0;
    checkOutput("flush ack_cycle", 32'(c_if), 32'd10);
    checkOutput("flush ack_count", 32'(cnt),  32'd1);
    checkOutput("flush if_data",   d,         32'h00100073);
    @(posedge clk_in);
    #1;

    // Asynchronous reset in the middle of a word store.
    preload(32'h00000700, 32'h44332211);
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = 1'b1;
    bus.mem_size_i  = 2'd2;
    bus.mem_addr_i  = 32'h00000700;
    bus.mem_wdata_i = 32'hA1B2C3D4;
    @(posedge clk_in);
    #1;
    @(posedge clk_in);
    #1;
    @(negedge clk_in);
    checkOutput("rst pre_wr",   {31'd0, bus.mem_wr}, 32'd1);
    checkOutput("rst pre_addr", bus.mem_a,           32'h00000701);
    #1;
    rst_in = 1'b0;
    #1;
    checkOutput("rst mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    checkOutput("rst mem_a",  bus.mem_a,           32'd0);
    checkOutput("rst acks",   {30'd0, bus.if_ack_o, bus.mem_ack_o}, 32'd0);
    bus.mem_req_i = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (bus.mem_ack_o || bus.if_ack_o || bus.mem_wr) cnt++;
    end
    checkOutput("rst quiet", 32'(cnt), 32'd0);
    shadow[32'h700] = 8'hD4;
    checkOutput("rst byte0", {24'd0, ram_rd(32'h700)}, {24'd0, sh_rd(32'h700)});
    checkOutput("rst byte1", {24'd0, ram_rd(32'h701)}, {24'd0, sh_rd(32'h701)});
    @(posedge clk_in);
    #1;

    // Random traffic against the shadow-memory model.
    for (int t = 0; t < 40; t++) begin
      bit          r_mem;
      bit          r_we;
      logic [1:0]  r_size;
      logic [31:0] r_addr;
      logic [31:0] r_wdata;
      int          r_n;
      int          r_s;
      int          r_l;
      r_mem   = ($urandom_range(0, 3) != 0);
      r_we    = r_mem && ($urandom_range(0, 1) == 1);
      r_size  = r_mem ? 2'($urandom_range(0, 3)) : 2'd2;
      r_n     = n_of(r_size);
      case ($urandom_range(0, 2))
        0:       r_addr = $urandom;
        1:       r_addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        default: r_addr = 32'($urandom_range(1, 64));
      endcase
      if (r_addr == 32'd0) r_addr = 32'd4;
      r_wdata = $urandom;
      r_s = 0;
      r_l = 0;
      if ($urandom_range(0, 1) == 1) begin
        r_s = $urandom_range(1, r_n);
        r_l = $urandom_range(1, 3);
      end
      applyStimulus($sformatf("rnd%0d", t), r_mem, r_we, r_size, r_addr, r_wdata, r_s, r_l,
                    model_ack(r_we, r_n, r_s, r_l), !r_we, model_read(r_addr, r_n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
